// File: rtl/gate_response_checker_pkg.sv
// rtl/gate_response_checker_pkg.sv - shared state encodings and truth-table constants
package gate_response_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Expected gate output indexed by {a,b}
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_NAND = 4'b0111;

endpackage

// File: rtl/gate_response_checker_expect.sv
// rtl/gate_response_checker_expect.sv - truth-table lookup of the expected gate output
module gate_expect
  import gate_response_checker_pkg::*;
#(
  parameter logic [3:0] TRUTH_TABLE = TT_AND
) (
  input  logic a,
  input  logic b,
  output logic expected
);

  // Pure lookup so per-gate checkers can share it
  assign expected = TRUTH_TABLE[{a, b}];

endmodule

// File: rtl/gate_response_checker.sv
// rtl/gate_response_checker.sv - samples a 2-input gate and scores it against a truth table
module gate_response_checker
  import gate_response_checker_pkg::*;
#(
  parameter logic [3:0]  TRUTH_TABLE      = TT_AND,
  parameter int unsigned NUM_SAMPLES      = 4,
  parameter int unsigned CNT_W            = 8,
  parameter bit          REQUIRE_COVERAGE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             sample,
  input  logic             a,
  input  logic             b,
  input  logic             out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] sample_count,
  output logic [3:0]       coverage,
  output logic             first_fail_valid,
  output logic [2:0]       first_fail
);

  state_t state, next_state;
  logic expected;
  logic accept, mismatch, end_now;
  logic busy_next, done_next;
  logic [CNT_W-1:0] err_next, cnt_next;
  logic [3:0] cov_next;

  gate_expect #(.TRUTH_TABLE(TRUTH_TABLE)) u_expect (
    .a        (a),
    .b        (b),
    .expected (expected)
  );

  // Accepted-sample decode and the post-sample counter values, including this cycle's sample
  always_comb begin
    accept   = (state == ST_RUN) && sample && !start;
    mismatch = (out != expected);
    err_next = err_count;
    cnt_next = sample_count;
    cov_next = coverage;
    if (accept) begin
      if (sample_count != '1) cnt_next = sample_count + CNT_W'(1);
      if (mismatch && err_count != '1) err_next = err_count + CNT_W'(1);
      cov_next = coverage | (4'b0001 << {a, b});
    end
    // start always wins, so a restart never ends the session
    end_now = (state == ST_RUN) && !start &&
              (stop || (accept && NUM_SAMPLES != 0 && 32'(cnt_next) == NUM_SAMPLES));
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (start) next_state = ST_RUN;
      ST_RUN:  if (start) next_state = ST_RUN;
               else if (end_now) next_state = ST_DONE;
      ST_DONE: if (start) next_state = ST_RUN;
      default: next_state = ST_IDLE;
    endcase
  end

  // Status outputs follow the state being entered so they are registered without extra lag
  always_comb begin
    busy_next = (next_state == ST_RUN);
    done_next = (next_state == ST_DONE);
  end

  // Status output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= busy_next;
      done <= done_next;
    end
  end

  // Counters, coverage, first-fail capture and the verdict latched on entry to DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count        <= '0;
      sample_count     <= '0;
      coverage         <= 4'b0000;
      first_fail_valid <= 1'b0;
      first_fail       <= 3'b000;
      pass             <= 1'b0;
    end else if (start) begin
      err_count        <= '0;
      sample_count     <= '0;
      coverage         <= 4'b0000;
      first_fail_valid <= 1'b0;
      first_fail       <= 3'b000;
      pass             <= 1'b0;
    end else begin
      err_count    <= err_next;
      sample_count <= cnt_next;
      coverage     <= cov_next;
      if (accept && mismatch && !first_fail_valid) begin
        first_fail_valid <= 1'b1;
        first_fail       <= {a, b, out};
      end
      if (end_now)
        pass <= (err_next == '0) && (!REQUIRE_COVERAGE || cov_next == 4'hF);
    end
  end

endmodule

// File: tb/tb_gate_response_checker.sv
// tb/tb_gate_response_checker.sv - directed scoreboard bench for gate_response_checker
module tb_gate_response_checker;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] err;
    logic [7:0] cnt;
    logic [3:0] cov;
    logic       ffv;
    logic [2:0] ff;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a = 1'b0, b = 1'b0, out = 1'b0;
  logic [2:0] start_v = '0, stop_v = '0, sample_v = '0;

  logic [2:0] busy_w, done_w, pass_w, ffv_w;
  logic [7:0] err_w [3];
  logic [7:0] cnt_w [3];
  logic [3:0] cov_w [3];
  logic [2:0] ff_w  [3];
  logic [1:0] err2, cnt2;

  int checks = 0;
  int errors = 0;

  // Reference model state, one slot per instance
  int         m_err [3];
  int         m_cnt [3];
  bit         m_run [3];
  bit         m_done[3];
  bit         m_pass[3];
  bit         m_ffv [3];
  logic [3:0] m_cov [3];
  logic [2:0] m_ff  [3];
  int         m_n   [3] = '{4, 0, 0};
  int         m_max [3] = '{255, 255, 3};
  bit         m_req [3] = '{1'b1, 1'b1, 1'b0};
  logic [3:0] tt = 4'b1000;

  exp_t sb[$];

  always #5 clk = ~clk;

  gate_response_checker #(.TRUTH_TABLE(4'b1000), .NUM_SAMPLES(4), .CNT_W(8), .REQUIRE_COVERAGE(1'b1)) u0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .stop(stop_v[0]), .sample(sample_v[0]),
    .a(a), .b(b), .out(out), .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
    .err_count(err_w[0]), .sample_count(cnt_w[0]), .coverage(cov_w[0]),
    .first_fail_valid(ffv_w[0]), .first_fail(ff_w[0]));

  gate_response_checker #(.TRUTH_TABLE(4'b1000), .NUM_SAMPLES(0), .CNT_W(8), .REQUIRE_COVERAGE(1'b1)) u1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .stop(stop_v[1]), .sample(sample_v[1]),
    .a(a), .b(b), .out(out), .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
    .err_count(err_w[1]), .sample_count(cnt_w[1]), .coverage(cov_w[1]),
    .first_fail_valid(ffv_w[1]), .first_fail(ff_w[1]));

  gate_response_checker #(.TRUTH_TABLE(4'b1000), .NUM_SAMPLES(0), .CNT_W(2), .REQUIRE_COVERAGE(1'b0)) u2 (
    .clk(clk), .rst(rst), .start(start_v[2]), .stop(stop_v[2]), .sample(sample_v[2]),
    .a(a), .b(b), .out(out), .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]),
    .err_count(err2), .sample_count(cnt2), .coverage(cov_w[2]),
    .first_fail_valid(ffv_w[2]), .first_fail(ff_w[2]));

  assign err_w[2] = {6'b0, err2};
  assign cnt_w[2] = {6'b0, cnt2};

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic model_clear(input int i);
    m_err[i] = 0; m_cnt[i] = 0; m_cov[i] = 4'b0000;
    m_ffv[i] = 1'b0; m_ff[i] = 3'b000; m_pass[i] = 1'b0;
  endtask

  function automatic exp_t model_snapshot(input int i);
    exp_t e;
    e.busy = m_run[i];
    e.done = m_done[i];
    e.pass = m_pass[i];
    e.err  = 8'(m_err[i]);
    e.cnt  = 8'(m_cnt[i]);
    e.cov  = m_cov[i];
    e.ffv  = m_ffv[i];
    e.ff   = m_ff[i];
    return e;
  endfunction

  task automatic compare_outputs(input int i, input exp_t e);
    check($sformatf("u%0d.busy", i), {7'b0, busy_w[i]}, {7'b0, e.busy});
    check($sformatf("u%0d.done", i), {7'b0, done_w[i]}, {7'b0, e.done});
    check($sformatf("u%0d.pass", i), {7'b0, pass_w[i]}, {7'b0, e.pass});
    check($sformatf("u%0d.err_count", i), err_w[i], e.err);
    check($sformatf("u%0d.sample_count", i), cnt_w[i], e.cnt);
    check($sformatf("u%0d.coverage", i), {4'b0, cov_w[i]}, {4'b0, e.cov});
    check($sformatf("u%0d.first_fail_valid", i), {7'b0, ffv_w[i]}, {7'b0, e.ffv});
    check($sformatf("u%0d.first_fail", i), {5'b0, ff_w[i]}, {5'b0, e.ff});
  endtask

  // One clock of stimulus on instance i; expected results queued at drive time, popped after the edge
  task automatic step(input int i, input bit st, input bit sp, input bit smp,
                      input bit ia, input bit ib, input bit io);
    exp_t e;
    @(negedge clk);
    start_v[i] = st; stop_v[i] = sp; sample_v[i] = smp;
    a = ia; b = ib; out = io;
    if (st) begin
      model_clear(i);
      m_run[i] = 1'b1;
      m_done[i] = 1'b0;
    end else if (m_run[i]) begin
      if (smp) begin
        if (m_cnt[i] < m_max[i]) m_cnt[i]++;
        m_cov[i][{ia, ib}] = 1'b1;
        if (io != tt[{ia, ib}]) begin
          if (m_err[i] < m_max[i]) m_err[i]++;
          if (!m_ffv[i]) begin
            m_ffv[i] = 1'b1;
            m_ff[i] = {ia, ib, io};
          end
        end
      end
      if (sp || (m_n[i] != 0 && m_cnt[i] == m_n[i])) begin
        m_run[i] = 1'b0;
        m_done[i] = 1'b1;
        m_pass[i] = (m_err[i] == 0) && (!m_req[i] || m_cov[i] == 4'hF);
      end
    end
    sb.push_back(model_snapshot(i));
    @(posedge clk);
    #1;
    start_v[i] = 1'b0; stop_v[i] = 1'b0; sample_v[i] = 1'b0;
    e = sb.pop_front();
    compare_outputs(i, e);
  endtask

  task automatic check_reset_values(input string tag);
    for (int i = 0; i < 3; i++) begin
      check({tag, ".busy"}, {7'b0, busy_w[i]}, 8'h00);
      check({tag, ".done"}, {7'b0, done_w[i]}, 8'h00);
      check({tag, ".pass"}, {7'b0, pass_w[i]}, 8'h00);
      check({tag, ".err"}, err_w[i], 8'h00);
      check({tag, ".cnt"}, cnt_w[i], 8'h00);
      check({tag, ".cov"}, {4'b0, cov_w[i]}, 8'h00);
      check({tag, ".ffv"}, {7'b0, ffv_w[i]}, 8'h00);
      check({tag, ".ff"}, {5'b0, ff_w[i]}, 8'h00);
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      model_clear(i);
      m_run[i] = 1'b0;
      m_done[i] = 1'b0;
    end
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;

    // AND, NUM_SAMPLES=4, all correct: ends itself on the fourth sample
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 1, 0, 0);
    step(0, 0, 0, 1, 1, 1, 1);
    step(0, 0, 0, 1, 0, 1, 0);
    check("and_ok.done", {7'b0, done_w[0]}, 8'h01);
    check("and_ok.pass", {7'b0, pass_w[0]}, 8'h01);
    check("and_ok.cnt", cnt_w[0], 8'd4);
    check("and_ok.cov", {4'b0, cov_w[0]}, 8'h0F);
    // Samples while DONE are ignored
    step(0, 0, 0, 1, 1, 1, 0);
    step(0, 0, 0, 1, 0, 0, 1);

    // Same sequence with out stuck high at 10 and 01
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 1, 0, 1);
    step(0, 0, 0, 1, 1, 1, 1);
    step(0, 0, 0, 1, 0, 1, 1);
    check("and_bad.err", err_w[0], 8'd2);
    check("and_bad.first_fail", {5'b0, ff_w[0]}, 8'b101);
    check("and_bad.pass", {7'b0, pass_w[0]}, 8'h00);

    // NUM_SAMPLES=0 with coverage required: partial coverage fails
    step(1, 1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0, 0, 0);
    step(1, 0, 0, 1, 1, 1, 1);
    step(1, 0, 1, 0, 0, 0, 0);
    check("cov_req.cov", {4'b0, cov_w[1]}, 8'b1001);
    check("cov_req.pass", {7'b0, pass_w[1]}, 8'h00);

    // sample+stop in one cycle still counts the sample
    step(1, 1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0, 0, 0);
    step(1, 0, 1, 1, 1, 1, 1);
    check("sample_stop.cnt", cnt_w[1], 8'd2);

    // start+stop in one cycle restarts with cleared results
    step(1, 1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0, 1, 1);
    step(1, 1, 1, 0, 0, 0, 0);
    check("start_stop.busy", {7'b0, busy_w[1]}, 8'h01);
    check("start_stop.err", err_w[1], 8'h00);

    // start+sample drops the sample, then two samples with one error before an async reset
    step(1, 1, 0, 1, 0, 1, 1);
    step(1, 0, 0, 1, 1, 0, 1);
    step(1, 0, 0, 1, 1, 1, 1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset_values("async_rst");
    for (int i = 0; i < 3; i++) begin
      model_clear(i);
      m_run[i] = 1'b0;
      m_done[i] = 1'b0;
    end
    @(negedge clk);
    rst = 1'b0;
    step(1, 1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 1, 1, 1);
    step(1, 0, 1, 0, 0, 0, 0);
    check("post_rst.err", err_w[1], 8'h00);
    check("post_rst.cnt", cnt_w[1], 8'd1);

    // CNT_W=2: five mismatches saturate both counters at 3
    step(2, 1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) step(2, 0, 0, 1, 0, 0, 1);
    check("sat.err", err_w[2], 8'd3);
    check("sat.cnt", cnt_w[2], 8'd3);
    step(2, 0, 1, 0, 0, 0, 0);

    // Coverage not required: 00 and 11 correct is a pass
    step(2, 1, 0, 0, 0, 0, 0);
    step(2, 0, 0, 1, 0, 0, 0);
    step(2, 0, 0, 1, 1, 1, 1);
    step(2, 0, 1, 0, 0, 0, 0);
    check("nocov.pass", {7'b0, pass_w[2]}, 8'h01);
    check("nocov.cov", {4'b0, cov_w[2]}, 8'b1001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
